xadc_conv_arbiter: RTL



---
 rtl/xadc_conv_arbiter_if.sv | 26 ++
 rtl/xadc_conv_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/xadc_conv_arbiter_if.sv
// Requester and XADC-side signals of the conversion arbiter.
// slave: the arbiter side. master: the requester/ADC environment side.
// Carries level requests, grant/done/result, and the convst/eoc/data path.
interface xadc_conv_arbiter_if #(
  parameter int NB_DATA = 12
);
  logic [1:0]         i_req;
  logic [1:0]         o_grant;
  logic [1:0]         o_done;
  logic [NB_DATA-1:0] o_data;
  logic               o_timeout;
  logic               o_busy;
  logic               o_adc_convst;
  logic               i_adc_eoc;
  logic [15:0]        i_adc_data;

  modport slave (
    input  i_req, i_adc_eoc, i_adc_data,
    output o_grant, o_done, o_data, o_timeout, o_busy, o_adc_convst
  );

  modport master (
    output i_req, i_adc_eoc, i_adc_data,
    input  o_grant, o_done, o_data, o_timeout, o_busy, o_adc_convst
  );
endinterface

// File: rtl/xadc_conv_arbiter.sv
// Round-robin share of the XADC event-mode path; averages 2^NB_AVG_LOG2 samples per grant.
// Latency: 1 + 2^NB_AVG_LOG2*(CONVST_CYCLES + eoc wait) + 1 cycles; all outputs registered.
// No backpressure: requests are level, sampled only in IDLE; eoc waits are bounded by TIMEOUT_CYCLES.
module xadc_conv_arbiter #(
  parameter int NB_DATA        = 12,
  parameter int NB_AVG_LOG2    = 2,
  parameter int CONVST_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  i_rst,
  xadc_conv_arbiter_if.slave   bus
);

  localparam int ACC_W = NB_DATA + NB_AVG_LOG2;
  localparam int SW    = NB_AVG_LOG2 + 1;
  localparam int NSMP  = 1 << NB_AVG_LOG2;
  localparam int CMAX  = (CONVST_CYCLES > TIMEOUT_CYCLES) ? CONVST_CYCLES : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CONVST   = 2'd1,
    S_WAIT_EOC = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cyc_q, cyc_d;      // convst width counter, reused as eoc timeout counter
  logic [SW-1:0]      smp_q, smp_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               owner_q, owner_d;  // 0 = sensor controller, 1 = debug
  logic               last_q, last_d;    // requester served most recently

  logic [1:0]         grant_d, done_d;
  logic [NB_DATA-1:0] data_d;
  logic               timeout_d, busy_d, convst_d;

  logic [NB_DATA-1:0] sample;
  logic [ACC_W-1:0]   acc_sum;

  assign sample  = bus.i_adc_data[15 -: NB_DATA];
  assign acc_sum = acc_q + ACC_W'(sample);

  // Next-state, counters, arbitration and next registered output values.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    smp_d     = smp_q;
    acc_d     = acc_q;
    owner_d   = owner_q;
    last_d    = last_q;
    done_d    = 2'b00;
    data_d    = bus.o_data;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.i_req) begin
          // With both requesting, the one not served last wins.
          owner_d = (bus.i_req == 2'b11) ? ~last_q : bus.i_req[1];
          last_d  = owner_d;
          acc_d   = '0;
          smp_d   = '0;
          cyc_d   = '0;
          state_d = S_CONVST;
        end
      end
      S_CONVST: begin
        if (cyc_q == CW'(CONVST_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_WAIT_EOC;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_WAIT_EOC: begin
        // eoc is checked first so it wins a tie with the timeout.
        if (bus.i_adc_eoc) begin
          acc_d = acc_sum;
          smp_d = smp_q + SW'(1);
          cyc_d = '0;
          if (smp_q == SW'(NSMP - 1)) begin
            state_d = S_DONE;
            done_d  = owner_q ? 2'b10 : 2'b01;
            data_d  = acc_sum[NB_AVG_LOG2 +: NB_DATA];
          end else begin
            state_d = S_CONVST;
          end
        end else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_DONE;
          done_d    = owner_q ? 2'b10 : 2'b01;
          data_d    = '0;
          timeout_d = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    grant_d  = (state_d == S_IDLE) ? 2'b00 : (owner_d ? 2'b10 : 2'b01);
    busy_d   = (state_d != S_IDLE);
    convst_d = (state_d == S_CONVST);
  end

  // State, datapath and output registers; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q          <= S_IDLE;
      cyc_q            <= '0;
      smp_q            <= '0;
      acc_q            <= '0;
      owner_q          <= 1'b0;
      last_q           <= 1'b1;
      bus.o_grant      <= 2'b00;
      bus.o_done       <= 2'b00;
      bus.o_data       <= '0;
      bus.o_timeout    <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_adc_convst <= 1'b0;
    end else begin
      state_q          <= state_d;
      cyc_q            <= cyc_d;
      smp_q            <= smp_d;
      acc_q            <= acc_d;
      owner_q          <= owner_d;
      last_q           <= last_d;
      bus.o_grant      <= grant_d;
      bus.o_done       <= done_d;
      bus.o_data       <= data_d;
      bus.o_timeout    <= timeout_d;
      bus.o_busy       <= busy_d;
      bus.o_adc_convst <= convst_d;
    end
  end

endmodule
